spi_cmd_dec: RTL and testbench
==============================

// Module: spi_cmd_dec
// PURPOSE
//  Command decoder between the SPI byte transceiver and the register/program stores.
//  Parses framed SPI byte streams into CSR byte reads/writes and PROM 32-bit word writes.
//  Auto-increments the address on every data byte.
//  Returns CSR read data to the transceiver for shifting out on the following SPI byte.
// PARAMETERS
//  CSR_AW   12  CSR byte address width (4 bits from cmd byte + 8 from low byte)
//  PROM_AW  20  PROM word address width (4 + 8 + 8)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  ss_i         in   1        slave select, synchronised to clk; 1 = idle/frame end
//  rx_data_i    in   8        received byte from transceiver
//  rx_valid_i   in   1        1-cycle strobe: rx_data_i valid
//  tx_data_o    out  8        byte to shift out on the next SPI byte
//  tx_valid_o   out  1        1-cycle strobe: transceiver loads tx_data_o
//  csr_addr_o   out  CSR_AW   CSR byte address
//  csr_we_o     out  1        1-cycle CSR write strobe
//  csr_re_o     out  1        1-cycle CSR read strobe; csr_rdata_i valid next cycle
//  csr_wdata_o  out  8        CSR write data
//  csr_rdata_i  in   8        CSR read data (1-cycle latency after csr_re_o)
//  prom_addr_o  out  PROM_AW  PROM word address
//  prom_wdata_o out  32       PROM write word
//  prom_we_o    out  1        1-cycle PROM write strobe
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; address and byte counters 0.
//  Cmd byte {w, rsv, tgt[1:0], ahi[3:0]}:
//   - w=1 write, w=0 read; rsv ignored.
//   - tgt 00 = CSR, 01 = PROM, 10/11 = reserved.
//  FSM, advanced only on rx_valid_i:
//   - IDLE --cmd--> ADDR_L (CSR) | ADDR_M (PROM) | DISCARD (reserved).
//   - ADDR_M: addr[15:8] = byte -> ADDR_L.
//   - ADDR_L: addr[7:0] = byte -> DATA. For CSR read, the first csr_re_o issues at this address.
//   - DATA: stays in DATA until frame end.
//  ss_i high in any state: next cycle -> IDLE.
//   - Partial PROM word discarded; no strobe issued.
//   - Pending tx strobe still issued.
//   - ss_i high has priority over a simultaneous rx_valid_i; that byte is dropped.
//  CSR write, in DATA:
//   - Each byte: csr_we_o=1, csr_wdata_o=byte, csr_addr_o=addr at N+1; addr++ after.
//  CSR read:
//   - rx_valid_i at cycle N (ADDR_L or DATA byte): csr_re_o=1 with csr_addr_o=addr at N+1.
//   - csr_rdata_i captured at N+2; tx_data_o=rdata, tx_valid_o=1 at N+2.
//   - addr++ after each DATA byte, so the DATA byte read at N+1 is the following address.
//   - Incoming DATA byte values are ignored.
//  PROM write:
//   - Bytes packed little-endian: 1st -> [7:0], 4th -> [31:24].
//   - On 4th byte: prom_we_o=1 at N+1 with prom_wdata_o and prom_addr_o; word addr++; byte count -> 0.
//   - PROM read is unsupported: returns 0x00 and issues no strobes.
//  Tx for every other received byte: tx_data_o=0x00, tx_valid_o=1 at N+2.
//   - Exactly one tx_valid_o per accepted rx_valid_i.
//  Address wrap: CSR 0xFFF -> 0x000, PROM 0xFFFFF -> 0x00000; no error indication.
//  Back-to-back rx_valid_i is never closer than 8 clk, so no internal queue is needed.
//  rst_n assertion mid-frame: immediate return to reset state; no strobes.
// TESTING
//  1. Write: ss=0; bytes 80,03,99,00 -> csr_we_o @0x003 data 0x99, then @0x004 data 0x00; tx bytes all 00.
//  2. Read: 08,01,00 with csr[0x801]=0xAB -> csr_re_o @0x801 after byte 2; tx strobe 0xAB before byte 3.
//  3. Burst read: 09,00,00,00,00 -> csr_re_o @0x900,0x901,0x902,0x903; tx stream 00,00,c[900],c[901],c[902].
//  4. PROM: 90,00,00,EF,BE,AD,DE,80,F1,01,09
//     -> prom_we_o @0x00000 = 0xDEADBEEF;
//     -> prom_we_o @0x00001 = 0x0901F180.
//  5. Abort: PROM frame ends after 2 data bytes (ss=1) -> no prom_we_o; next frame 80,05,11 writes csr[0x005]=0x11.
//  6. Wrap: 8F,FF,AA,BB -> writes 0xFFF=AA, 0x000=BB; 20,00,55 (reserved tgt) -> no strobes, tx 00 x3.

Source files
------------

// File: rtl/spi_cmd_dec_if.sv
// spi_cmd_dec_if
//   Bundles the transceiver-side byte handshake and the CSR/PROM store buses
//   of spi_cmd_dec. Signal names keep their original _i/_o suffixes as seen
//   from the decoder.
// Modports
//   slave  : decoder view (spi_cmd_dec)
//   master : environment view (transceiver + stores)
// Signals
//   ss_i, rx_data_i[7:0], rx_valid_i    transceiver -> decoder
//   tx_data_o[7:0], tx_valid_o          decoder -> transceiver
//   csr_addr_o[CSR_AW-1:0], csr_we_o, csr_re_o, csr_wdata_o[7:0]
//   csr_rdata_i[7:0]                    CSR store -> decoder
//   prom_addr_o[PROM_AW-1:0], prom_wdata_o[31:0], prom_we_o
interface spi_cmd_dec_if #(
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned PROM_AW = 20
);
  logic               ss_i;
  logic [7:0]         rx_data_i;
  logic               rx_valid_i;
  logic [7:0]         tx_data_o;
  logic               tx_valid_o;
  logic [CSR_AW-1:0]  csr_addr_o;
  logic               csr_we_o;
  logic               csr_re_o;
  logic [7:0]         csr_wdata_o;
  logic [7:0]         csr_rdata_i;
  logic [PROM_AW-1:0] prom_addr_o;
  logic [31:0]        prom_wdata_o;
  logic               prom_we_o;

  modport slave (
    input  ss_i, rx_data_i, rx_valid_i, csr_rdata_i,
    output tx_data_o, tx_valid_o, csr_addr_o, csr_we_o, csr_re_o,
           csr_wdata_o, prom_addr_o, prom_wdata_o, prom_we_o
  );

  modport master (
    output ss_i, rx_data_i, rx_valid_i, csr_rdata_i,
    input  tx_data_o, tx_valid_o, csr_addr_o, csr_we_o, csr_re_o,
           csr_wdata_o, prom_addr_o, prom_wdata_o, prom_we_o
  );
endinterface

// File: rtl/spi_cmd_dec.sv
// spi_cmd_dec
//   Command decoder between the SPI byte transceiver and the CSR/PROM stores.
//   A frame (ss_i low) starts with a command byte {w, rsv, tgt[1:0], ahi[3:0]}
//   followed by address bytes and data bytes. CSR frames give byte reads or
//   writes with address auto-increment; PROM write frames pack four bytes
//   little-endian into one 32-bit word write. Every accepted byte produces
//   exactly one tx strobe two cycles later (CSR read data or 0x00).
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    spi_cmd_dec_if.slave (transceiver handshake, CSR and PROM buses)
module spi_cmd_dec #(
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned PROM_AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_cmd_dec_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_M,
    S_ADDR_L,
    S_DATA,
    S_DISCARD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]         w_byte;
  logic               w_accept;
  logic               w_csr_we;
  logic               w_csr_re;
  logic               w_prom_we;
  logic [CSR_AW-1:0]  w_csr_base;
  logic [PROM_AW-1:0] w_prom_base;

  // frame context captured from the command byte
  logic               r_wr;
  logic               r_prom;
  logic [3:0]         r_ahi;
  logic [7:0]         r_amid;

  // running pointers and registered bus outputs
  logic [CSR_AW-1:0]  r_csr_ptr;
  logic [CSR_AW-1:0]  r_csr_addr;
  logic [7:0]         r_csr_wdata;
  logic               r_csr_we;
  logic               r_csr_re;
  logic [PROM_AW-1:0] r_prom_ptr;
  logic [PROM_AW-1:0] r_prom_addr;
  logic [31:0]        r_prom_wdata;
  logic               r_prom_we;
  logic [23:0]        r_word;
  logic [1:0]         r_bcnt;

  // tx return pipeline: byte at N -> r_p1 at N+1 -> r_tx_valid at N+2
  logic               r_p1;
  logic               r_p1_rd;
  logic               r_tx_valid;
  logic               r_tx_rd;
  logic [7:0]         r_tx_data;

  assign w_byte      = bus.rx_data_i;
  assign w_accept    = bus.rx_valid_i & ~bus.ss_i;
  assign w_csr_base  = CSR_AW'({r_ahi, w_byte});
  assign w_prom_base = PROM_AW'({r_ahi, r_amid, w_byte});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ss_i wins over a coincident rx_valid_i: the byte is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_csr_we    = 1'b0;
    w_csr_re    = 1'b0;
    w_prom_we   = 1'b0;
    if (bus.ss_i) begin
      w_state_nxt = S_IDLE;
    end else if (bus.rx_valid_i) begin
      unique case (r_state)
        S_IDLE: begin
          case (w_byte[5:4])
            2'b00:   w_state_nxt = S_ADDR_L;
            2'b01:   w_state_nxt = S_ADDR_M;
            default: w_state_nxt = S_DISCARD;
          endcase
        end
        S_ADDR_M: w_state_nxt = S_ADDR_L;
        S_ADDR_L: begin
          w_state_nxt = S_DATA;
          w_csr_re    = ~r_prom & ~r_wr;
        end
        S_DATA: begin
          w_csr_we  = ~r_prom & r_wr;
          w_csr_re  = ~r_prom & ~r_wr;
          w_prom_we = r_prom & r_wr & (r_bcnt == 2'd3);
        end
        S_DISCARD: w_state_nxt = S_DISCARD;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= 1'b0;
      r_prom       <= 1'b0;
      r_ahi        <= '0;
      r_amid       <= '0;
      r_csr_ptr    <= '0;
      r_csr_addr   <= '0;
      r_csr_wdata  <= '0;
      r_csr_we     <= 1'b0;
      r_csr_re     <= 1'b0;
      r_prom_ptr   <= '0;
      r_prom_addr  <= '0;
      r_prom_wdata <= '0;
      r_prom_we    <= 1'b0;
      r_word       <= '0;
      r_bcnt       <= '0;
      r_p1         <= 1'b0;
      r_p1_rd      <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_rd      <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_csr_we   <= w_csr_we;
      r_csr_re   <= w_csr_re;
      r_prom_we  <= w_prom_we;

      // tx pipeline keeps running across ss_i so a pending strobe still fires
      r_p1       <= w_accept;
      r_p1_rd    <= w_csr_re;
      r_tx_valid <= r_p1;
      r_tx_rd    <= r_p1_rd;
      if (r_tx_rd) begin
        r_tx_data <= bus.csr_rdata_i;
      end else if (r_p1) begin
        r_tx_data <= '0;
      end

      if (w_csr_we) begin
        r_csr_wdata <= w_byte;
      end

      if (bus.ss_i) begin
        r_bcnt <= '0;
      end else if (bus.rx_valid_i) begin
        unique case (r_state)
          S_IDLE: begin
            r_wr   <= w_byte[7];
            r_prom <= (w_byte[5:4] == 2'b01);
            r_ahi  <= w_byte[3:0];
            r_bcnt <= '0;
          end
          S_ADDR_M: r_amid <= w_byte;
          S_ADDR_L: begin
            if (r_prom) begin
              r_prom_ptr <= w_prom_base;
            end else if (r_wr) begin
              r_csr_ptr <= w_csr_base;
            end else begin
              // read issues at the base now, so DATA bytes start at base+1
              r_csr_addr <= w_csr_base;
              r_csr_ptr  <= w_csr_base + CSR_AW'(1);
            end
          end
          S_DATA: begin
            if (w_csr_we | w_csr_re) begin
              r_csr_addr <= r_csr_ptr;
              r_csr_ptr  <= r_csr_ptr + CSR_AW'(1);
            end
            if (r_prom & r_wr) begin
              r_bcnt <= r_bcnt + 2'd1;
              case (r_bcnt)
                2'd0: r_word[7:0]   <= w_byte;
                2'd1: r_word[15:8]  <= w_byte;
                2'd2: r_word[23:16] <= w_byte;
                default: begin
                  r_prom_wdata <= {w_byte, r_word};
                  r_prom_addr  <= r_prom_ptr;
                  r_prom_ptr   <= r_prom_ptr + PROM_AW'(1);
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  // read data arrives the cycle the strobe is up, so it bypasses the register
  assign bus.tx_data_o    = r_tx_rd ? bus.csr_rdata_i : r_tx_data;
  assign bus.tx_valid_o   = r_tx_valid;
  assign bus.csr_addr_o   = r_csr_addr;
  assign bus.csr_we_o     = r_csr_we;
  assign bus.csr_re_o     = r_csr_re;
  assign bus.csr_wdata_o  = r_csr_wdata;
  assign bus.prom_addr_o  = r_prom_addr;
  assign bus.prom_wdata_o = r_prom_wdata;
  assign bus.prom_we_o    = r_prom_we;

endmodule

// File: tb/tb_spi_cmd_dec.sv
module tb_spi_cmd_dec;
  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned PROM_AW = 20;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] ev_t;   // {delta[7:0], addr[23:0], data[31:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_dec_if #(.CSR_AW(CSR_AW), .PROM_AW(PROM_AW)) bus ();

  spi_cmd_dec #(.CSR_AW(CSR_AW), .PROM_AW(PROM_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] ref_mem [4096];
  logic [7:0] csr_mem [4096];

  // CSR store: one-cycle read latency; contents seeded from the model during reset
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.csr_rdata_i <= '0;
      for (int i = 0; i < 4096; i++) csr_mem[i] <= ref_mem[i];
    end else begin
      if (bus.csr_re_o) bus.csr_rdata_i <= csr_mem[bus.csr_addr_o];
      if (bus.csr_we_o) csr_mem[bus.csr_addr_o] <= bus.csr_wdata_o;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_rx = 0;

  ev_t exp_wr[$], exp_rd[$], exp_pw[$], exp_tx[$];
  ev_t obs_wr[$], obs_rd[$], obs_pw[$], obs_tx[$];

  function automatic ev_t mk_ev(input int d, input int a, input logic [31:0] dat);
    return {8'(d), 24'(a), dat};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock, sampling outputs on the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.csr_we_o) obs_wr.push_back(mk_ev(cyc - last_rx, int'(bus.csr_addr_o), 32'(bus.csr_wdata_o)));
    if (bus.csr_re_o) obs_rd.push_back(mk_ev(cyc - last_rx, int'(bus.csr_addr_o), 32'd0));
    if (bus.prom_we_o) obs_pw.push_back(mk_ev(cyc - last_rx, int'(bus.prom_addr_o), bus.prom_wdata_o));
    if (bus.tx_valid_o) obs_tx.push_back(mk_ev(cyc - last_rx, 0, 32'(bus.tx_data_o)));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_ss);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    if (with_ss) bus.ss_i = 1'b1;
    last_rx = cyc;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'($urandom);
    repeat (9) tick();
  endtask

  // Reference: the frame as a list of accepted bytes -> expected bus events
  task automatic model_frame(input bq_t q, input int n);
    logic [7:0]  cmd;
    logic [7:0]  tdat[$];
    logic [31:0] word;
    int base, a, nw;
    if (n == 0) return;
    cmd = q[0];
    tdat = {};
    for (int k = 0; k < n; k++) tdat.push_back(8'h00);
    if (cmd[5:4] == 2'b00 && n >= 2) begin
      base = int'({cmd[3:0], q[1]});
      for (int k = 1; k < n; k++) begin
        if (cmd[7]) begin
          if (k >= 2) begin
            a = (base + k - 2) % 4096;
            exp_wr.push_back(mk_ev(1, a, 32'(q[k])));
            ref_mem[a] = q[k];
          end
        end else begin
          a = (base + k - 1) % 4096;
          exp_rd.push_back(mk_ev(1, a, 32'd0));
          tdat[k] = ref_mem[a];
        end
      end
    end else if (cmd[5:4] == 2'b01 && cmd[7] && n >= 3) begin
      base = int'({cmd[3:0], q[1], q[2]});
      nw = (n - 3) / 4;
      for (int j = 0; j < nw; j++) begin
        word = {q[6 + 4*j], q[5 + 4*j], q[4 + 4*j], q[3 + 4*j]};
        exp_pw.push_back(mk_ev(1, (base + j) % (1 << 20), word));
      end
    end
    for (int k = 0; k < n; k++) exp_tx.push_back(mk_ev(2, 0, 32'(tdat[k])));
  endtask

  task automatic check_q(input string tag, input ev_t e[$], input ev_t o[$]);
    check({tag, "_count"}, 128'(o.size()), 128'(e.size()));
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < o.size()) ? 128'(o[i]) : {128{1'b1}}, 128'(e[i]));
  endtask

  task automatic check_all(input string tag);
    check_q({tag, "_csr_wr"}, exp_wr, obs_wr);
    check_q({tag, "_csr_rd"}, exp_rd, obs_rd);
    check_q({tag, "_prom_wr"}, exp_pw, obs_pw);
    check_q({tag, "_tx"}, exp_tx, obs_tx);
    exp_wr = {}; exp_rd = {}; exp_pw = {}; exp_tx = {};
    obs_wr = {}; obs_rd = {}; obs_pw = {}; obs_tx = {};
  endtask

  task automatic run_frame(input string tag, input bq_t q, input bit drop_last);
    int n;
    bus.ss_i = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < q.size(); i++) send_byte(q[i], drop_last && (i == q.size() - 1));
    n = drop_last ? q.size() - 1 : q.size();
    model_frame(q, n);
    bus.ss_i = 1'b1;
    repeat (3) tick();
    check_all(tag);
  endtask

  function automatic logic [127:0] out_vec();
    return 128'({bus.tx_data_o, bus.tx_valid_o, bus.csr_addr_o, bus.csr_we_o, bus.csr_re_o,
                 bus.csr_wdata_o, bus.prom_addr_o, bus.prom_wdata_o, bus.prom_we_o});
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t q;
    int kind, len;
    logic [7:0] c;
    bit drop;

    bus.ss_i       = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h801] = 8'hAB;

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", out_vec(), 128'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset_outputs", out_vec(), 128'd0);
    obs_wr = {}; obs_rd = {}; obs_pw = {}; obs_tx = {};

    q = {8'h80, 8'h03, 8'h99, 8'h00};                 run_frame("t1_write", q, 1'b0);
    q = {8'h08, 8'h01, 8'h00};                        run_frame("t2_read", q, 1'b0);
    q = {8'h09, 8'h00, 8'h00, 8'h00, 8'h00};          run_frame("t3_burst", q, 1'b0);
    q = {8'h90, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
         8'h80, 8'hF1, 8'h01, 8'h09};                 run_frame("t4_prom", q, 1'b0);
    q = {8'h90, 8'h00, 8'h00, 8'h11, 8'h22};          run_frame("t5_abort", q, 1'b0);
    q = {8'h80, 8'h05, 8'h11};                        run_frame("t5_after", q, 1'b0);
    q = {8'h8F, 8'hFF, 8'hAA, 8'hBB};                 run_frame("t6_wrap", q, 1'b0);
    q = {8'h20, 8'h00, 8'h55};                        run_frame("t6_rsvd", q, 1'b0);
    q = {8'h9F, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04,
         8'h05, 8'h06, 8'h07, 8'h08};                 run_frame("prom_wrap", q, 1'b0);
    q = {8'h10, 8'h12, 8'h34, 8'h01, 8'h02};          run_frame("prom_read", q, 1'b0);
    q = {8'h80, 8'h40, 8'h01, 8'h02};                 run_frame("ss_priority", q, 1'b1);

    // reset in the middle of a CSR write frame; next byte must be a command
    bus.ss_i = 1'b0;
    repeat (2) tick();
    q = {8'h80, 8'h10, 8'h22};
    foreach (q[i]) send_byte(q[i], 1'b0);
    model_frame(q, 3);
    rst_n = 1'b0;
    tick();
    check("midframe_reset_outputs", out_vec(), 128'd0);
    tick();
    rst_n = 1'b1;
    q = {8'h80, 8'h20, 8'h33};
    foreach (q[i]) send_byte(q[i], 1'b0);
    model_frame(q, 3);
    bus.ss_i = 1'b1;
    repeat (3) tick();
    check_all("midframe_reset");

    for (int f = 0; f < 40; f++) begin
      q = {};
      kind = $urandom_range(0, 6);
      c = 8'($urandom);
      case (kind)
        0:       c = {1'b1, c[6], 2'b00, c[3:0]};
        1:       c = {1'b0, c[6], 2'b00, c[3:0]};
        2:       c = {1'b1, c[6], 2'b01, c[3:0]};
        3:       c = {1'b0, c[6], 2'b01, c[3:0]};
        4:       c = {c[7], c[6], 1'b1, c[4], c[3:0]};
        5:       c = {c[7], c[6], 2'b00, 4'hF};
        default: c = {1'b1, c[6], 2'b01, 4'hF};
      endcase
      q.push_back(c);
      if (kind == 2 || kind == 3) q.push_back(8'($urandom));
      if (kind == 6) q.push_back(8'hFF);
      if (kind >= 5) q.push_back(8'(8'd253 + 8'($urandom_range(0, 2))));
      else           q.push_back(8'($urandom));
      len = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      drop = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rand%0d", f), q, drop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
